// File: rtl/instruction_fetch_m.sv
// -----------------------------------------------------------------------------
// instruction_fetch_m
//
// LEGv8 instruction fetch stage sitting directly in front of decoder_m.
// Owns the program counter, fetches one 32-bit word at a time from
// instruction memory over a req/ack handshake and hands each word, tagged
// with its PC, to the decoder over a valid/ready handshake.  Branch
// resolution from decode/execute redirects the PC; any fetch that was in
// flight when the redirect arrived is drained and its data discarded.
//
// Ports
//   clk           : clock, all state changes on the rising edge
//   reset         : asynchronous active-high reset
//   imem_req      : fetch request, held until imem_ack
//   imem_addr     : fetch address, stable while imem_req is high
//   imem_ack      : memory completed the request, imem_rdata valid
//   imem_rdata    : fetched instruction word
//   instruction   : instruction presented to the decoder
//   instr_pc      : PC of instruction
//   instr_valid   : instruction/instr_pc valid
//   decode_ready  : decoder accepts this cycle
//   br_uncond     : unconditional branch taken
//   br_cond       : conditional branch (CBZ/CBNZ)
//   br_zero       : condition result for br_cond
//   br_is_cb      : 1 -> 19-bit offset, 0 -> 26-bit offset
//   br_imm        : branch immediate field
//   br_pc         : PC of the branch instruction
//   fetch_count   : number of instructions accepted by the decoder
// -----------------------------------------------------------------------------
module instruction_fetch_m #(
  parameter int                  PC_WIDTH = 64,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                reset,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_ack,
  input  logic [31:0]         imem_rdata,
  output logic [31:0]         instruction,
  output logic [PC_WIDTH-1:0] instr_pc,
  output logic                instr_valid,
  input  logic                decode_ready,
  input  logic                br_uncond,
  input  logic                br_cond,
  input  logic                br_zero,
  input  logic                br_is_cb,
  input  logic [25:0]         br_imm,
  input  logic [PC_WIDTH-1:0] br_pc,
  output logic [31:0]         fetch_count
);

  // S_DROP: a redirect arrived while a request was outstanding; the old
  // request must still be completed (one outstanding request at most) and
  // its data thrown away before fetching from the new PC.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DROP = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [PC_WIDTH-1:0] r_pc;
  logic [PC_WIDTH-1:0] w_pc_next;
  logic [PC_WIDTH-1:0] r_addr;
  logic [PC_WIDTH-1:0] w_addr_next;
  logic [PC_WIDTH-1:0] r_instr_pc;
  logic [PC_WIDTH-1:0] w_instr_pc_next;
  logic [31:0]         r_instr;
  logic [31:0]         w_instr_next;
  logic [31:0]         r_count;
  logic [31:0]         w_count_next;
  logic                r_req;
  logic                w_req_next;
  logic                r_valid;
  logic                w_valid_next;

  logic                w_redirect;
  logic [PC_WIDTH-1:0] w_imm_sext;
  logic [PC_WIDTH-1:0] w_offset;
  logic [PC_WIDTH-1:0] w_target;

  // Branch target: sign-extend the selected immediate, scale to bytes, add to br_pc.
  always_comb begin
    w_redirect = br_uncond | (br_cond & br_zero);
    if (br_is_cb) begin
      w_imm_sext = {{(PC_WIDTH-19){br_imm[18]}}, br_imm[18:0]};
    end else begin
      w_imm_sext = {{(PC_WIDTH-26){br_imm[25]}}, br_imm};
    end
    w_offset = w_imm_sext << 2;
    // Modular add: targets wrap around the address space silently.
    w_target = br_pc + w_offset;
  end

  // Next-state, next-PC and capture logic for the fetch FSM.
  always_comb begin
    w_state_next    = r_state;
    w_pc_next       = r_pc;
    w_instr_next    = r_instr;
    w_instr_pc_next = r_instr_pc;
    w_count_next    = r_count;

    case (r_state)
      S_IDLE: begin
        w_state_next = S_REQ;
        if (w_redirect) begin
          w_pc_next = w_target;
        end else begin
          w_pc_next = r_pc;
        end
      end

      S_REQ: begin
        if (w_redirect) begin
          w_pc_next = w_target;
          if (imem_ack) begin
            // Data returned for a now-stale PC: drop it, refetch at once.
            w_state_next = S_REQ;
          end else begin
            w_state_next = S_DROP;
          end
        end else if (imem_ack) begin
          w_instr_next    = imem_rdata;
          w_instr_pc_next = r_pc;
          w_pc_next       = r_pc + PC_WIDTH'(3'd4);
          w_state_next    = S_OUT;
        end else begin
          w_state_next = S_REQ;
        end
      end

      S_DROP: begin
        if (w_redirect) begin
          w_pc_next = w_target;
        end else begin
          w_pc_next = r_pc;
        end
        if (imem_ack) begin
          w_state_next = S_REQ;
        end else begin
          w_state_next = S_DROP;
        end
      end

      S_OUT: begin
        // A redirect squashes the presented word even if the decoder is ready.
        if (w_redirect) begin
          w_pc_next    = w_target;
          w_state_next = S_REQ;
        end else if (decode_ready) begin
          w_count_next = r_count + 32'd1;
          w_state_next = S_REQ;
        end else begin
          w_state_next = S_OUT;
        end
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Moore outputs computed from the next state so they leave the block registered.
  always_comb begin
    w_req_next   = (w_state_next == S_REQ) || (w_state_next == S_DROP);
    w_valid_next = (w_state_next == S_OUT);
    // While draining a stale request the bus address must not move; in S_REQ
    // r_addr already equals the PC of the outstanding request.
    if (w_state_next == S_DROP) begin
      w_addr_next = r_addr;
    end else begin
      w_addr_next = w_pc_next;
    end
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_pc       <= RESET_PC;
      r_addr     <= RESET_PC;
      r_instr    <= 32'd0;
      r_instr_pc <= '0;
      r_count    <= 32'd0;
      r_req      <= 1'b0;
      r_valid    <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_pc       <= w_pc_next;
      r_addr     <= w_addr_next;
      r_instr    <= w_instr_next;
      r_instr_pc <= w_instr_pc_next;
      r_count    <= w_count_next;
      r_req      <= w_req_next;
      r_valid    <= w_valid_next;
    end
  end

  assign imem_req    = r_req;
  assign imem_addr   = r_addr;
  assign instruction = r_instr;
  assign instr_pc    = r_instr_pc;
  assign instr_valid = r_valid;
  assign fetch_count = r_count;

endmodule

// File: tb/tb_instruction_fetch_m.sv
// -----------------------------------------------------------------------------
// Bench for instruction_fetch_m.  A transaction-level reference model keeps
// the architectural picture (next PC, outstanding request and whether it is
// stale, word held for the decoder, delivered count) and is stepped once per
// clock with the same inputs the DUT saw; every cycle the DUT outputs are
// compared against it.  Directed steps cover the listed scenarios, followed
// by a randomized run and a reset in the middle of a request.
// -----------------------------------------------------------------------------
module tb_instruction_fetch_m;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instruction;
  logic [63:0] instr_pc;
  logic        instr_valid;
  logic        decode_ready;
  logic        br_uncond;
  logic        br_cond;
  logic        br_zero;
  logic        br_is_cb;
  logic [25:0] br_imm;
  logic [63:0] br_pc;
  logic [31:0] fetch_count;

  int checks = 0;
  int errors = 0;

  // reference model state
  bit          m_run;
  bit          m_req;
  bit          m_stale;
  bit          m_valid;
  logic [63:0] m_pc;
  logic [63:0] m_addr;
  logic [31:0] m_instr;
  logic [63:0] m_ipc;
  logic [31:0] m_count;

  instruction_fetch_m #(.PC_WIDTH(64), .RESET_PC(64'd0)) dut (
    .clk          (clk),
    .reset        (reset),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .instruction  (instruction),
    .instr_pc     (instr_pc),
    .instr_valid  (instr_valid),
    .decode_ready (decode_ready),
    .br_uncond    (br_uncond),
    .br_cond      (br_cond),
    .br_zero      (br_zero),
    .br_is_cb     (br_is_cb),
    .br_imm       (br_imm),
    .br_pc        (br_pc),
    .fetch_count  (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // target = br_pc + 4 * signed offset, computed with plain integer arithmetic
  function automatic logic [63:0] ref_target(input logic [63:0] pc, input logic cb,
                                             input logic [25:0] imm);
    longint off;
    if (cb) begin
      off = longint'(imm[18:0]);
      if (imm[18]) off = off - 64'sd524288;
    end else begin
      off = longint'(imm);
      if (imm[25]) off = off - 64'sd67108864;
    end
    return pc + 64'(off * 64'sd4);
  endfunction

  task automatic model_reset();
    m_run = 0; m_req = 0; m_stale = 0; m_valid = 0;
    m_pc = 64'd0; m_addr = 64'd0; m_instr = 32'd0; m_ipc = 64'd0; m_count = 32'd0;
  endtask

  task automatic model_step();
    logic [63:0] tgt;
    bit          redir;
    tgt   = ref_target(br_pc, br_is_cb, br_imm);
    redir = br_uncond | (br_cond & br_zero);
    if (!m_run) begin
      m_run = 1;
      if (redir) m_pc = tgt;
      m_req = 1; m_stale = 0; m_addr = m_pc;
    end else if (m_req) begin
      if (m_stale) begin
        if (redir) m_pc = tgt;
        if (imem_ack) begin m_stale = 0; m_addr = m_pc; end
      end else if (redir) begin
        m_pc = tgt;
        if (imem_ack) m_addr = m_pc;
        else m_stale = 1;
      end else if (imem_ack) begin
        m_valid = 1; m_instr = imem_rdata; m_ipc = m_addr;
        m_pc = m_pc + 64'd4; m_req = 0;
      end
    end else if (m_valid) begin
      if (redir) begin
        m_valid = 0; m_pc = tgt; m_req = 1; m_addr = m_pc;
      end else if (decode_ready) begin
        m_count = m_count + 32'd1; m_valid = 0; m_req = 1; m_addr = m_pc;
      end
    end
  endtask

  task automatic compare();
    check("imem_req",    64'(imem_req),    64'(m_req));
    check("instr_valid", 64'(instr_valid), 64'(m_valid));
    check("fetch_count", 64'(fetch_count), 64'(m_count));
    check("instruction", 64'(instruction), 64'(m_instr));
    check("instr_pc",    instr_pc,         m_ipc);
    if (m_req) check("imem_addr", imem_addr, m_addr);
  endtask

  task automatic cycle();
    @(posedge clk);
    if (reset) model_reset();
    else model_step();
    #1;
    compare();
  endtask

  task automatic no_branch();
    br_uncond = 0; br_cond = 0; br_zero = 0; br_is_cb = 0; br_imm = 26'd0; br_pc = 64'd0;
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!instr_valid && n < 20) begin
      cycle();
      n++;
    end
    check(tag, 64'(instr_valid), 64'd1);
  endtask

  // one cycle of unconditional redirect to pc with ack high: always lands in S_REQ at pc
  task automatic jump(input logic [63:0] pc);
    br_uncond = 1; br_is_cb = 0; br_imm = 26'd0; br_pc = pc; imem_ack = 1;
    cycle();
    no_branch();
    check("jump_addr", imem_addr, pc);
  endtask

  initial begin
    reset = 1; imem_ack = 0; imem_rdata = 32'd0; decode_ready = 0;
    no_branch();
    model_reset();
    #1;
    compare();

    // 1: reset then zero-wait streaming
    repeat (3) cycle();
    check("rst_req", 64'(imem_req), 64'd0);
    check("rst_cnt", 64'(fetch_count), 64'd0);
    reset = 0; imem_ack = 1; imem_rdata = 32'h8A040041; decode_ready = 1;
    for (int k = 0; k < 3; k++) begin
      wait_valid("t1_wait");
      check("t1_pc", instr_pc, 64'(4 * k));
      check("t1_instr", 64'(instruction), 64'h8A040041);
      cycle();
      check("t1_count", 64'(fetch_count), 64'(k + 1));
    end

    // 2: slow memory, stalled decoder
    imem_ack = 0; decode_ready = 0;
    repeat (3) begin
      cycle();
      check("t2_req", 64'(imem_req), 64'd1);
      check("t2_addr", imem_addr, 64'h0C);
    end
    imem_ack = 1; imem_rdata = 32'h12345678;
    cycle();
    imem_ack = 0;
    repeat (4) begin
      cycle();
      check("t2_valid", 64'(instr_valid), 64'd1);
      check("t2_pc", instr_pc, 64'h0C);
      check("t2_count", 64'(fetch_count), 64'd3);
    end
    decode_ready = 1;
    cycle();
    check("t2_accept", 64'(fetch_count), 64'd4);
    decode_ready = 0;

    // 3: unconditional branch from S_OUT, positive and negative offsets
    imem_ack = 1;
    cycle();
    check("t3_valid", 64'(instr_valid), 64'd1);
    imem_ack = 0; decode_ready = 1;
    br_uncond = 1; br_is_cb = 0; br_imm = 26'd4; br_pc = 64'h10;
    cycle();
    no_branch();
    check("t3_drop", 64'(instr_valid), 64'd0);
    check("t3_addr", imem_addr, 64'h20);
    check("t3_count", 64'(fetch_count), 64'd4);
    imem_ack = 1; decode_ready = 0;
    cycle();
    imem_ack = 0;
    br_uncond = 1; br_is_cb = 0; br_imm = 26'h3FFFFFF; br_pc = 64'h10;
    cycle();
    no_branch();
    check("t3_neg", imem_addr, 64'h0C);

    // 4: conditional branch, 19-bit offset
    jump(64'h40);
    br_cond = 1; br_zero = 0; br_is_cb = 1; br_imm = {7'h55, 19'h7FFFE}; br_pc = 64'h40;
    imem_ack = 1; imem_rdata = $urandom;
    cycle();
    check("t4_pc", instr_pc, 64'h40);
    decode_ready = 1;
    cycle();
    check("t4_seq", imem_addr, 64'h44);
    br_zero = 1;
    cycle();
    no_branch();
    check("t4_taken", imem_addr, 64'h38);
    decode_ready = 0;

    // 5: redirect while a request is unacked
    jump(64'h8);
    imem_ack = 0; br_uncond = 1; br_pc = 64'h100;
    cycle();
    no_branch();
    repeat (2) begin
      check("t5_hold", imem_addr, 64'h8);
      check("t5_req", 64'(imem_req), 64'd1);
      cycle();
    end
    imem_ack = 1; imem_rdata = 32'hDEADBEEF;
    cycle();
    check("t5_nov", 64'(instr_valid), 64'd0);
    check("t5_addr", imem_addr, 64'h100);
    imem_ack = 0;
    cycle();
    check("t5_nov2", 64'(instr_valid), 64'd0);
    check("t5_count", 64'(fetch_count), 64'd5);

    // 6: redirect coincident with ack and with decode_ready
    imem_ack = 1; imem_rdata = $urandom;
    cycle();
    decode_ready = 1; br_uncond = 1; br_pc = 64'h200;
    cycle();
    check("t6_nov", 64'(instr_valid), 64'd0);
    check("t6_count", 64'(fetch_count), 64'd5);
    check("t6_addr", imem_addr, 64'h200);
    br_pc = 64'h300;
    cycle();
    no_branch();
    check("t6_ack_nov", 64'(instr_valid), 64'd0);
    check("t6_ack_addr", imem_addr, 64'h300);
    imem_ack = 0;
    cycle();
    check("t6_count2", 64'(fetch_count), 64'd5);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      int r;
      imem_ack     = 1'($urandom_range(0, 1));
      decode_ready = ($urandom_range(0, 9) < 6);
      imem_rdata   = $urandom;
      no_branch();
      r = $urandom_range(0, 19);
      br_is_cb = 1'($urandom_range(0, 1));
      br_imm   = 26'($urandom);
      br_pc    = (r < 2) ? {32'($urandom), 32'($urandom)} : 64'($urandom_range(0, 4095));
      if (r == 0) br_uncond = 1;
      if (r == 1 || r == 4) begin br_cond = 1; br_zero = 1; end
      if (r == 2) begin br_cond = 1; br_zero = 0; end
      if (r == 3) br_zero = 1;
      cycle();
    end

    // reset in the middle of a request
    no_branch(); imem_ack = 0; decode_ready = 1;
    repeat (3) cycle();
    check("mid_req", 64'(imem_req), 64'd1);
    #2;
    reset = 1;
    model_reset();
    #1;
    compare();
    check("mid_rst_req", 64'(imem_req), 64'd0);
    check("mid_rst_cnt", 64'(fetch_count), 64'd0);
    cycle();
    reset = 0; imem_ack = 1; imem_rdata = 32'hCAFEF00D;
    wait_valid("post_rst_wait");
    check("post_rst_pc", instr_pc, 64'd0);
    check("post_rst_instr", 64'(instruction), 64'hCAFEF00D);
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_m.md
Name: instruction_fetch_m

Overview:
- Instruction fetch stage directly upstream of decoder_m.
- Holds the 64-bit LEGv8 PC and issues requests to instruction memory over a req/ack handshake.
- Presents each fetched 32-bit instruction and its PC to the decoder over a valid/ready handshake.
- Takes branch resolution inputs (Uncondbranch, Branch, zero, immediate), computes the target and redirects the PC, discarding stale fetches.

Parameters:
- PC_WIDTH, 64, width of PC and memory address.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- imem_req  output  1  fetch request; held high until imem_ack.
- imem_addr  output  PC_WIDTH  fetch address; stable while imem_req is high.
- imem_ack  input  1  memory has completed the request; imem_rdata is valid this cycle.
- imem_rdata  input  32  fetched instruction word.
- instruction  output  32  instruction to the decoder.
- instr_pc  output  PC_WIDTH  PC of instruction.
- instr_valid  output  1  instruction/instr_pc are valid.
- decode_ready  input  1  decoder accepts this cycle.
- br_uncond  input  1  Uncondbranch from decode/execute.
- br_cond  input  1  Branch (CBZ/CBNZ) from decode/execute.
- br_zero  input  1  condition result for br_cond.
- br_is_cb  input  1  1: offset is br_imm[18:0]; 0: offset is br_imm[25:0].
- br_imm  input  26  branch immediate field.
- br_pc  input  PC_WIDTH  PC of the branch instruction.
- fetch_count  output  32  count of instructions delivered to the decoder.

Behaviour:
Reset (async, while reset is high):
- state=S_IDLE, pc=RESET_PC, instruction=0, instr_pc=0, instr_valid=0, fetch_count=0, imem_req=0.

Redirect:
- redirect = br_uncond | (br_cond & br_zero); combinational, sampled each cycle.
- Offset is sign-extended to PC_WIDTH from bit 18 (br_is_cb=1) or bit 25 (br_is_cb=0), then shifted left 2.
- target = br_pc + offset, modulo 2^PC_WIDTH (wraps, no overflow flag).

State machine (Moore outputs):
- imem_req=1 only in S_REQ and S_DROP.
- imem_addr = pc in S_REQ; the address latched at request issue in S_DROP.
- instr_valid=1 only in S_OUT.

Transitions:
- S_IDLE: always -> S_REQ next cycle. If redirect: pc<=target.
- S_REQ, no ack, no redirect: stay.
- S_REQ, ack, no redirect: instruction<=imem_rdata, instr_pc<=pc, pc<=pc+4, -> S_OUT.
- S_REQ, ack & redirect: discard data, pc<=target, -> S_REQ (new request next cycle).
- S_REQ, redirect, no ack: pc<=target, keep the old address, -> S_DROP.
- S_DROP: imem_req stays high with the old address. On ack: discard data, -> S_REQ. Redirect here: pc<=target again, stay in or leave per ack.
- S_OUT, redirect: instr_valid drops next cycle, pc<=target, -> S_REQ. Redirect beats decode_ready; fetch_count is not incremented.
- S_OUT, decode_ready, no redirect: fetch_count<=fetch_count+1 (wraps at 2^32), -> S_REQ.
- S_OUT, otherwise: hold instruction/instr_pc stable.

Timing and limits:
- Latency: ack in cycle N -> instr_valid high in N+1.
- Minimum 2 cycles per instruction with zero-wait memory.
- pc increments only on accepted (non-discarded) fetches.
- At most one outstanding memory request at any time.
- Reset mid-request abandons it; the memory must tolerate imem_req dropping without ack.

Test Plan:
1. Reset with RESET_PC=0, hold 3 cycles -> all outputs 0. Release, ack tied 1, rdata=32'h8A040041, decode_ready=1 -> instr_pc 0,4,8 on successive valids; instruction=8A040041; fetch_count 1,2,3.
2. Ack delayed 3 cycles, decode_ready low 4 cycles -> imem_addr stable while req high. instruction/instr_pc held. fetch_count unchanged until accept.
3. br_uncond=1, br_is_cb=0, br_imm=26'd4, br_pc=0x10 in S_OUT -> valid dropped, next imem_addr=0x20. A 26'h3FFFFFF offset with br_pc=0x10 -> 0x0C.
4. br_cond=1, br_is_cb=1, br_imm[18:0]=19'h7FFFE, br_pc=0x40: br_zero=1 -> next addr 0x38. br_zero=0 -> sequential 0x44 unaffected.
5. Redirect to 0x100 while a request to 0x8 is unacked (S_DROP), ack after 2 cycles with rdata=0xDEADBEEF -> data never presented, next request addr=0x100, fetch_count unchanged.
6. Redirect coincident with ack and with decode_ready -> redirect wins. No valid for the discarded word; fetch_count not incremented.
